bist_sig_checker: RTL and testbench
===================================

Name: bist_sig_checker

Overview:
- Response-evaluation stage directly downstream of the c432 MISR.
- Accepts the 4-bit signature the MISR emits at the end of each pattern session and compares it against a golden signature.
- Runs a fixed number of sessions per test, with a per-session timeout, and reports a single pass/fail result.
- Sits between the MISR outputs and the top-level BIST status outputs.

Parameters:
- SIG_W, 4, signature width in bits; matches the MISR width.
- GOLDEN, 4'hA, expected fault-free signature; width SIG_W.
- NUM_SESSIONS, 4, signatures required per test run; legal range 1..15.
- TIMEOUT, 16, maximum cycles spent waiting for each signature; legal range 2..255.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a test run; honoured only in IDLE.
- sig_in  input  SIG_W  signature from the MISR.
- sig_valid  input  1  qualifies sig_in for one cycle.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at the end of a run.
- pass  output  1  result of the last run; held until the next start.
- timeout  output  1  last run aborted on a missing signature; held until the next start.
- mismatch_cnt  output  4  number of failing sessions in the current/last run; saturates at 15.
- session_cnt  output  4  sessions completed in the current/last run.
- last_sig  output  SIG_W  most recently captured signature.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; all outputs 0; internal timer and fail flag 0. Reset applied mid-run aborts the run; done is not pulsed.
- States: IDLE, WAIT, CMP, DONE. All outputs are registered.
- IDLE:
  - start=1 → clear mismatch_cnt, session_cnt, pass, timeout, fail flag and timer; go to WAIT.
  - sig_valid in IDLE is ignored.
- WAIT:
  - The timer increments every cycle.
  - sig_valid=1 → last_sig<=sig_in; go to CMP.
  - Else, if timer==TIMEOUT-1 → timeout<=1; go to DONE.
  - If sig_valid and the timeout limit coincide, sig_valid wins.
  - start is ignored in WAIT.
- CMP (exactly one cycle):
  - If last_sig!=GOLDEN: mismatch_cnt increments (saturating at 15) and the fail flag is set.
  - session_cnt increments.
  - If the incremented session_cnt == NUM_SESSIONS, go to DONE; otherwise go to WAIT with the timer cleared to 0.
  - sig_valid asserted in CMP is dropped. The upstream MISR guarantees at least 2 cycles between signatures.
- DONE (one cycle):
  - done=1.
  - pass<=~fail_flag & ~timeout, where fail_flag includes the final session's comparison.
  - Go to IDLE.
  - start in DONE is ignored.
- Latency: final sig_valid sampled at edge t → CMP during cycle t+1 → done=1 and pass valid during cycle t+2.
- Timeout latency: first WAIT cycle at edge s → done at cycle s+TIMEOUT+1 if no sig_valid arrives.
- pass, timeout, mismatch_cnt, session_cnt and last_sig hold their values through IDLE until the next accepted start.
- Widths: counters use unsigned arithmetic. The session compare is performed at 4 bits. The timer is 8 bits.

Decomposition:
- Shared package bist_pkg holds:
  - the state enum (IDLE, WAIT, CMP, DONE);
  - the SIG_W default;
  - the default GOLDEN constant for c432.
- The MISR and the top level import bist_pkg.
- Single module; no sub-module. The timer and counters are simple enough to keep inline.

Test Plan (all with GOLDEN=4'hA, NUM_SESSIONS=4, TIMEOUT=16):
1. All match: start, then 4 sig_valid pulses with sig_in=4'hA spaced 3 cycles apart → done one cycle, two cycles after the last valid; pass=1, mismatch_cnt=0, session_cnt=4, timeout=0.
2. One mismatch: sessions 4'hA, 4'h3, 4'hA, 4'hA → pass=0, mismatch_cnt=1, last_sig=4'hA, session_cnt=4.
3. Timeout: start, deliver 2 valid signatures, then none → timeout=1, pass=0, session_cnt=2; done arrives 17 cycles after the second session's WAIT entry.
4. Boundary and ignored inputs:
   - sig_valid on exactly the 16th WAIT cycle → accepted, no timeout.
   - sig_valid while IDLE → last_sig unchanged.
   - start while busy → no restart; counters unaffected.
5. Reset mid-run: rst asserted during WAIT of session 3 → next edge all outputs 0, state IDLE, no done pulse. A new start then runs a clean 4-session pass.
6. Back-to-back runs: a second start is given the cycle after done, with a failing first run → the pass/timeout/counters from the first run are cleared on start, and the second run reports independently (pass=1).

Source files
------------

// File: rtl/bist_pkg.sv
// Shared BIST definitions: checker state encoding, signature width and the
// fault-free c432 signature.
package bist_pkg;

   localparam int SIG_W_DEF = 4;

   localparam logic [3:0] C432_GOLDEN = 4'hA;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      CMP,
      DONE
   } bist_state_t;

   // Four-bit increment that sticks at all-ones instead of wrapping.
   function automatic logic [3:0] satInc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/bist_sig_checker.sv
// Response evaluator behind the c432 MISR: collects one signature per session,
// compares each against the golden value, and reports a single pass/fail
// (or timeout) verdict per test run.
module bist_sig_checker
   import bist_pkg::*;
#(
   parameter int               SIG_W        = SIG_W_DEF,
   parameter logic [SIG_W-1:0] GOLDEN       = SIG_W'(C432_GOLDEN),
   parameter int               NUM_SESSIONS = 4,
   parameter int               TIMEOUT      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [SIG_W-1:0] sig_in,
   input  logic             sig_valid,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             timeout,
   output logic [3:0]       mismatch_cnt,
   output logic [3:0]       session_cnt,
   output logic [SIG_W-1:0] last_sig
);

   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
   localparam logic [3:0] SESS_LAST  = 4'(NUM_SESSIONS);

   bist_state_t state;
   logic [7:0]  timer;
   logic        failFlag;
   logic [3:0]  sessNext;
   logic        sigBad;

   assign sessNext = session_cnt + 4'd1;
   assign sigBad   = (last_sig != GOLDEN);

   // Run controller: sequences sessions, times out missing signatures and
   // registers every status output so downstream logic sees clean levels.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         timer        <= 8'd0;
         failFlag     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         timeout      <= 1'b0;
         mismatch_cnt <= 4'd0;
         session_cnt  <= 4'd0;
         last_sig     <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mismatch_cnt <= 4'd0;
                  session_cnt  <= 4'd0;
                  pass         <= 1'b0;
                  timeout      <= 1'b0;
                  failFlag     <= 1'b0;
                  timer        <= 8'd0;
                  busy         <= 1'b1;
                  state        <= WAIT;
               end
            end
            WAIT: begin
               timer <= timer + 8'd1;
               if (sig_valid) begin
                  last_sig <= sig_in;
                  state    <= CMP;
               end else if (timer == TIMER_LAST) begin
                  timeout <= 1'b1;
                  pass    <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            CMP: begin
               if (sigBad) begin
                  mismatch_cnt <= satInc4(mismatch_cnt);
                  failFlag     <= 1'b1;
               end
               session_cnt <= sessNext;
               if (sessNext == SESS_LAST) begin
                  pass  <= ~(failFlag | sigBad) & ~timeout;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  timer <= 8'd0;
                  state <= WAIT;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bist_sig_checker.sv
// Scoreboard bench for bist_sig_checker: each run's expected verdict is
// derived from the list of signatures delivered, queued at issue time, and
// checked by an independent monitor whenever done pulses.
module tb_bist_sig_checker;

   localparam int         NUM_SESS = 4;
   localparam int         TMO      = 16;
   localparam logic [3:0] GOLD     = 4'hA;

   typedef struct {
      int passV;
      int tmoV;
      int mismV;
      int sessV;
      int lastV;
      int doneCyc;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] sig_in;
   logic       sig_valid;
   logic       busy;
   logic       done;
   logic       pass;
   logic       timeout;
   logic [3:0] mismatch_cnt;
   logic [3:0] session_cnt;
   logic [3:0] last_sig;

   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;
   int   modelLast = 0;
   exp_t sb[$];
   exp_t monExp;

   logic [3:0] tSigs[4];
   int         tWaits[4];

   bist_sig_checker #(
      .SIG_W(4),
      .GOLDEN(GOLD),
      .NUM_SESSIONS(NUM_SESS),
      .TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .sig_in(sig_in),
      .sig_valid(sig_valid),
      .busy(busy),
      .done(done),
      .pass(pass),
      .timeout(timeout),
      .mismatch_cnt(mismatch_cnt),
      .session_cnt(session_cnt),
      .last_sig(last_sig)
   );

   // Free-running clock and an edge counter used for latency expectations.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_done", 1, 0);
         end else begin
            monExp = sb.pop_front();
            checkOutput("pass", int'(pass), monExp.passV);
            checkOutput("timeout", int'(timeout), monExp.tmoV);
            checkOutput("mismatch_cnt", int'(mismatch_cnt), monExp.mismV);
            checkOutput("session_cnt", int'(session_cnt), monExp.sessV);
            checkOutput("last_sig", int'(last_sig), monExp.lastV);
            checkOutput("done_cycle", cyc, monExp.doneCyc);
            checkOutput("busy_at_done", int'(busy), 1);
         end
      end
   end

   // Pulse start from the current (IDLE) cycle and confirm the run state was cleared.
   task automatic startRun(output int entry);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      entry = cyc;
      checkOutput("start_busy", int'(busy), 1);
      checkOutput("start_clr_pass", int'(pass), 0);
      checkOutput("start_clr_timeout", int'(timeout), 0);
      checkOutput("start_clr_mism", int'(mismatch_cnt), 0);
      checkOutput("start_clr_sess", int'(session_cnt), 0);
   endtask

   // Present one signature so that it is sampled on edge number target.
   task automatic sendSig(input int target, input logic [3:0] s, input bit alsoStart, output int v);
      while (cyc < target - 1) begin
         @(posedge clk); #1;
      end
      sig_in    = s;
      sig_valid = 1'b1;
      start     = alsoStart;
      @(posedge clk); #1;
      sig_valid = 1'b0;
      start     = 1'b0;
      sig_in    = 4'($urandom);
      v         = cyc;
   endtask

   // One complete run: model the verdict, queue it, then drive the signatures.
   task automatic applyStimulus(input int nSig, input bit poke);
      exp_t e;
      int   entry, v, k;
      e.mismV = 0;
      for (int i = 0; i < nSig; i++)
         if (tSigs[i] != GOLD) e.mismV++;
      if (e.mismV > 15) e.mismV = 15;
      e.sessV = nSig;
      e.tmoV  = (nSig < NUM_SESS) ? 1 : 0;
      e.passV = (e.tmoV == 0 && e.mismV == 0) ? 1 : 0;
      e.lastV = (nSig > 0) ? int'(tSigs[nSig-1]) : modelLast;
      modelLast = e.lastV;
      entry = cyc + 1;
      v = entry;
      for (int i = 0; i < nSig; i++) begin
         v = entry + tWaits[i];
         entry = v + 1;
      end
      e.doneCyc = (nSig == NUM_SESS) ? v + 1 : entry + TMO;
      sb.push_back(e);

      startRun(entry);
      for (int i = 0; i < nSig; i++) begin
         sendSig(entry + tWaits[i], tSigs[i], poke && (i == 1), v);
         entry = v + 1;
      end
      k = 0;
      while (sb.size() != 0 && k < 60) begin
         @(posedge clk); #1;
         k++;
      end
      if (sb.size() != 0) begin
         checkOutput("done_wait_expired", 0, 1);
         sb.delete();
      end
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int entry, v, nSig;
      rst = 1'b1; start = 1'b0; sig_valid = 1'b0; sig_in = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_pass", int'(pass), 0);
      checkOutput("rst_timeout", int'(timeout), 0);
      checkOutput("rst_mism", int'(mismatch_cnt), 0);
      checkOutput("rst_sess", int'(session_cnt), 0);
      checkOutput("rst_last", int'(last_sig), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] all-match run");
      tSigs = '{4'hA, 4'hA, 4'hA, 4'hA}; tWaits = '{3, 3, 3, 3};
      applyStimulus(4, 1'b0);

      $display("[TB] single mismatch run");
      tSigs = '{4'hA, 4'h3, 4'hA, 4'hA}; tWaits = '{2, 5, 1, 7};
      applyStimulus(4, 1'b0);

      $display("[TB] timeout run");
      tSigs = '{4'hA, 4'hA, 4'h0, 4'h0}; tWaits = '{4, 6, 1, 1};
      applyStimulus(2, 1'b0);

      $display("[TB] timer boundary with start while busy");
      tSigs = '{4'hA, 4'hA, 4'hA, 4'hA}; tWaits = '{16, 16, 1, 16};
      applyStimulus(4, 1'b1);

      $display("[TB] sig_valid while idle");
      sig_in = 4'h5; sig_valid = 1'b1;
      @(posedge clk); #1;
      sig_valid = 1'b0;
      @(posedge clk); #1;
      checkOutput("idle_last_sig", int'(last_sig), modelLast);
      checkOutput("idle_busy", int'(busy), 0);

      $display("[TB] reset mid-run");
      startRun(entry);
      sendSig(entry + 3, 4'hA, 1'b0, v);
      sendSig(v + 1 + 3, 4'h3, 1'b0, v);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("midrst_busy", int'(busy), 0);
      checkOutput("midrst_done", int'(done), 0);
      checkOutput("midrst_pass", int'(pass), 0);
      checkOutput("midrst_timeout", int'(timeout), 0);
      checkOutput("midrst_mism", int'(mismatch_cnt), 0);
      checkOutput("midrst_sess", int'(session_cnt), 0);
      checkOutput("midrst_last", int'(last_sig), 0);
      modelLast = 0;
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      tSigs = '{4'hA, 4'hA, 4'hA, 4'hA}; tWaits = '{2, 3, 4, 5};
      applyStimulus(4, 1'b0);

      $display("[TB] back-to-back runs");
      tSigs = '{4'h5, 4'hA, 4'hC, 4'hA}; tWaits = '{1, 2, 3, 2};
      applyStimulus(4, 1'b0);
      tSigs = '{4'hA, 4'hA, 4'hA, 4'hA}; tWaits = '{1, 2, 2, 2};
      applyStimulus(4, 1'b0);

      $display("[TB] randomized runs");
      for (int r = 0; r < 24; r++) begin
         for (int i = 0; i < 4; i++) begin
            tSigs[i]  = ($urandom_range(0, 2) != 0) ? GOLD : 4'($urandom);
            tWaits[i] = $urandom_range(1, 16);
         end
         nSig = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : NUM_SESS;
         applyStimulus(nSig, 1'($urandom_range(0, 1)));
      end

      repeat (5) @(posedge clk);
      #1;
      checkOutput("final_idle", int'(busy), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
